motor_dac_adc_spi: RTL and testbench

- Physical-side peer of the motor PID loop.
- Takes 16-bit DAC setpoint words (valid pulse) and shifts them to the motor-drive DAC over SPI.
- On each read trigger, it starts an ADC conversion, shifts the 16-bit Ufeed result back, and returns it with a one-cycle valid pulse.
- One shared transaction FSM serializes DAC writes and ADC reads.

---
 rtl/motor_dac_adc_spi.sv | 257 +++++++++++++++++++++++++
 tb/tb_motor_dac_adc_spi.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_dac_adc_spi.sv
// SPI front end for the motor loop: serializes DAC setpoint writes and ADC Ufeed reads through one FSM.
// Define MOTOR_ADC_AVG4_EN to average four back-to-back ADC conversions per read.
module motor_dac_adc_spi #(
  parameter int         CLK_DIV    = 4,
  parameter logic [7:0] DAC_CMD    = 8'h30,
  parameter int         CONV_PULSE = 4,
  parameter int         CONV_WAIT  = 100,
  parameter int         CS_IDLE    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        motor_data_in_en_i,
  input  logic [15:0] motor_data_in_i,
  input  logic        motor_rd_en_i,
  output logic        motor_Ufeed_en_o,
  output logic [15:0] motor_Ufeed_o,
  output logic        busy_o,
  output logic        dac_sclk_o,
  output logic        dac_cs_n_o,
  output logic        dac_mosi_o,
  output logic        adc_convst_o,
  output logic        adc_sclk_o,
  output logic        adc_cs_n_o,
  input  logic        adc_miso_i
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DAC_SHIFT = 3'd1;
  localparam logic [2:0] ST_ADC_CONV  = 3'd2;
  localparam logic [2:0] ST_ADC_SHIFT = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  localparam logic [15:0] LP_PH_RISE  = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_PH_FALL  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] LP_CONV_HI  = 16'(CONV_PULSE - 1);
  localparam logic [15:0] LP_CONV_END = 16'(CONV_PULSE + CONV_WAIT - 1);
  localparam logic [15:0] LP_GAP_END  = 16'(CS_IDLE - 1);
  localparam logic [4:0]  LP_DAC_LAST = 5'd23;
  localparam logic [4:0]  LP_ADC_LAST = 5'd15;

  logic [2:0]  r_state;
  logic [15:0] r_phase;
  logic [4:0]  r_bit;
  logic [23:0] r_dac_sr;
  logic [15:0] r_adc_sr;
  logic [15:0] r_word;
  logic        r_wr_pend;
  logic        r_rd_pend;
  logic        r_busy;
  logic        r_dac_sclk;
  logic        r_dac_cs_n;
  logic        r_dac_mosi;
  logic        r_adc_convst;
  logic        r_adc_sclk;
  logic        r_adc_cs_n;
  logic [15:0] r_ufeed;
  logic        r_ufeed_en;

  logic        w_idle;
  logic        w_take_rd;
  logic        w_take_wr;
  logic        w_rd_active;
  logic [15:0] w_word_src;
  logic        w_bit_rise;
  logic        w_bit_end;

`ifdef MOTOR_ADC_AVG4_EN
  logic [17:0] r_acc;
  logic [1:0]  r_avg_cnt;
  logic        r_avg_more;
  logic [17:0] w_sum;

  assign w_sum       = r_acc + {2'b00, r_adc_sr};
  assign w_rd_active = (r_state == ST_ADC_CONV) || (r_state == ST_ADC_SHIFT) ||
                       ((r_state == ST_GAP) && r_avg_more);
`else
  assign w_rd_active = (r_state == ST_ADC_CONV) || (r_state == ST_ADC_SHIFT);
`endif

  // A request may be taken straight from the input pins in IDLE; reads win over writes.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_take_rd  = w_idle && (r_rd_pend || motor_rd_en_i);
  assign w_take_wr  = w_idle && !w_take_rd && (r_wr_pend || motor_data_in_en_i);
  assign w_word_src = motor_data_in_en_i ? motor_data_in_i : r_word;
  assign w_bit_rise = (r_phase == LP_PH_RISE);
  assign w_bit_end  = (r_phase == LP_PH_FALL);

  // One-deep request capture: the newest write word wins, duplicate reads collapse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_word    <= 16'h0000;
    end else begin
      r_word    <= w_word_src;
      r_wr_pend <= w_take_wr ? 1'b0 : (r_wr_pend || motor_data_in_en_i);
      r_rd_pend <= w_take_rd ? 1'b0 : (r_rd_pend || (motor_rd_en_i && !w_rd_active));
    end
  end

  // Transaction FSM; every SPI pin is driven straight from a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_phase      <= 16'd0;
      r_bit        <= 5'd0;
      r_dac_sr     <= 24'd0;
      r_adc_sr     <= 16'd0;
      r_busy       <= 1'b0;
      r_dac_sclk   <= 1'b0;
      r_dac_cs_n   <= 1'b1;
      r_dac_mosi   <= 1'b0;
      r_adc_convst <= 1'b0;
      r_adc_sclk   <= 1'b0;
      r_adc_cs_n   <= 1'b1;
      r_ufeed      <= 16'd0;
      r_ufeed_en   <= 1'b0;
`ifdef MOTOR_ADC_AVG4_EN
      r_acc        <= 18'd0;
      r_avg_cnt    <= 2'd0;
      r_avg_more   <= 1'b0;
`endif
    end else begin
      r_ufeed_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_phase <= 16'd0;
          r_bit   <= 5'd0;
          if (w_take_rd) begin
            r_state      <= ST_ADC_CONV;
            r_busy       <= 1'b1;
            r_adc_convst <= 1'b1;
          end else if (w_take_wr) begin
            r_state    <= ST_DAC_SHIFT;
            r_busy     <= 1'b1;
            r_dac_cs_n <= 1'b0;
            r_dac_sr   <= {DAC_CMD, w_word_src};
            r_dac_mosi <= DAC_CMD[7];
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_DAC_SHIFT: begin
          if (w_bit_rise) begin
            r_dac_sclk <= 1'b1;
            r_phase    <= r_phase + 16'd1;
          end else if (w_bit_end) begin
            r_dac_sclk <= 1'b0;
            r_phase    <= 16'd0;
            if (r_bit == LP_DAC_LAST) begin
              r_state    <= ST_GAP;
              r_dac_cs_n <= 1'b1;
              r_dac_mosi <= 1'b0;
            end else begin
              r_bit      <= r_bit + 5'd1;
              r_dac_sr   <= {r_dac_sr[22:0], 1'b0};
              r_dac_mosi <= r_dac_sr[22];
            end
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        ST_ADC_CONV: begin
          if (r_phase == LP_CONV_END) begin
            r_state      <= ST_ADC_SHIFT;
            r_adc_convst <= 1'b0;
            r_adc_cs_n   <= 1'b0;
            r_phase      <= 16'd0;
            r_bit        <= 5'd0;
          end else begin
            r_phase <= r_phase + 16'd1;
            if (r_phase == LP_CONV_HI) begin
              r_adc_convst <= 1'b0;
            end else begin
              r_adc_convst <= r_adc_convst;
            end
          end
        end
        ST_ADC_SHIFT: begin
          if (w_bit_rise) begin
            r_adc_sclk <= 1'b1;
            r_adc_sr   <= {r_adc_sr[14:0], adc_miso_i};
            r_phase    <= r_phase + 16'd1;
          end else if (w_bit_end) begin
            r_adc_sclk <= 1'b0;
            r_phase    <= 16'd0;
            if (r_bit == LP_ADC_LAST) begin
              r_state    <= ST_GAP;
              r_adc_cs_n <= 1'b1;
`ifdef MOTOR_ADC_AVG4_EN
              if (r_avg_cnt == 2'd3) begin
                r_ufeed    <= w_sum[17:2];
                r_ufeed_en <= 1'b1;
                r_acc      <= 18'd0;
                r_avg_cnt  <= 2'd0;
                r_avg_more <= 1'b0;
              end else begin
                r_acc      <= w_sum;
                r_avg_cnt  <= r_avg_cnt + 2'd1;
                r_avg_more <= 1'b1;
              end
`else
              r_ufeed    <= r_adc_sr;
              r_ufeed_en <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + 5'd1;
            end
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_phase == LP_GAP_END) begin
            r_phase <= 16'd0;
`ifdef MOTOR_ADC_AVG4_EN
            if (r_avg_more) begin
              r_state      <= ST_ADC_CONV;
              r_adc_convst <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_phase      <= 16'd0;
          r_dac_sclk   <= 1'b0;
          r_dac_cs_n   <= 1'b1;
          r_dac_mosi   <= 1'b0;
          r_adc_convst <= 1'b0;
          r_adc_sclk   <= 1'b0;
          r_adc_cs_n   <= 1'b1;
        end
      endcase
    end
  end

  assign motor_Ufeed_en_o = r_ufeed_en;
  assign motor_Ufeed_o    = r_ufeed;
  assign busy_o           = r_busy;
  assign dac_sclk_o       = r_dac_sclk;
  assign dac_cs_n_o       = r_dac_cs_n;
  assign dac_mosi_o       = r_dac_mosi;
  assign adc_convst_o     = r_adc_convst;
  assign adc_sclk_o       = r_adc_sclk;
  assign adc_cs_n_o       = r_adc_cs_n;

endmodule

// File: tb/tb_motor_dac_adc_spi.sv
// Scoreboard bench for motor_dac_adc_spi: stimulus pushes expected frames, monitors pop and compare.
module tb_motor_dac_adc_spi;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        ufeed_en;
  logic [15:0] ufeed;
  logic        busy;
  logic        dac_sclk;
  logic        dac_cs_n;
  logic        dac_mosi;
  logic        convst;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        miso;

  always #5 clk = ~clk;

  motor_dac_adc_spi dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .motor_data_in_en_i (wr_en),
    .motor_data_in_i    (wr_data),
    .motor_rd_en_i      (rd_en),
    .motor_Ufeed_en_o   (ufeed_en),
    .motor_Ufeed_o      (ufeed),
    .busy_o             (busy),
    .dac_sclk_o         (dac_sclk),
    .dac_cs_n_o         (dac_cs_n),
    .dac_mosi_o         (dac_mosi),
    .adc_convst_o       (convst),
    .adc_sclk_o         (adc_sclk),
    .adc_cs_n_o         (adc_cs_n),
    .adc_miso_i         (miso)
  );

  typedef struct packed {
    logic        is_dac;
    logic [23:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sample_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          abort_dac = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic is_dac, input logic [23:0] v);
    exp_t e;
    e.is_dac = is_dac;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  task automatic push_sample(input logic [15:0] v);
`ifdef MOTOR_ADC_AVG4_EN
    repeat (4) sample_q.push_back(v);
`else
    sample_q.push_back(v);
`endif
  endtask

  // DAC frame monitor: rebuilds each 24-bit frame from MOSI on SCLK rising edges.
  logic        d_prev_cs   = 1'b1;
  logic        d_prev_sclk = 1'b0;
  logic [23:0] d_shift;
  int          d_bits, d_len;
  bit          d_overlap;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!dac_cs_n) begin
        if (d_prev_cs) begin
          d_shift = 24'd0; d_bits = 0; d_len = 0; d_overlap = 1'b0;
        end
        d_len++;
        if (dac_sclk && !d_prev_sclk) begin
          d_shift = {d_shift[22:0], dac_mosi};
          d_bits++;
        end
        if (!adc_cs_n) d_overlap = 1'b1;
      end else if (!d_prev_cs) begin
        if (abort_dac) begin
          abort_dac = 1'b0;
        end else begin
          check("dac_bits", d_bits, 32'd24);
          check("dac_len", d_len, 32'd192);
          check("dac_overlap", {31'd0, d_overlap}, 32'd0);
          if (exp_q.size() == 0) begin
            check("dac_unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("dac_order", {31'd0, e.is_dac}, 32'd1);
            check("dac_frame", {8'd0, d_shift}, {8'd0, e.val});
          end
        end
      end
      d_prev_cs   = dac_cs_n;
      d_prev_sclk = dac_sclk;
    end
  end

  // ADC slave model plus Ufeed monitor: drives MISO MSB first, changing after SCLK falls.
  logic        a_prev_cs   = 1'b1;
  logic        a_prev_sclk = 1'b0;
  logic [15:0] a_cur;
  int          a_idx, a_rises;
  bit          a_overlap;
  initial begin
    exp_t e;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      if (!adc_cs_n && a_prev_cs) begin
        if (sample_q.size() == 0) begin
          check("adc_sample_underflow", 32'd1, 32'd0);
          a_cur = 16'd0;
        end else begin
          a_cur = sample_q.pop_front();
        end
        a_idx = 15; a_rises = 0; a_overlap = 1'b0;
        miso = a_cur[15];
      end else if (!adc_cs_n && a_prev_sclk && !adc_sclk) begin
        if (a_idx > 0) a_idx--;
        miso = a_cur[a_idx];
      end
      if (!adc_cs_n && adc_sclk && !a_prev_sclk) a_rises++;
      if (!adc_cs_n && !dac_cs_n) a_overlap = 1'b1;
      if (adc_cs_n && !a_prev_cs && !rst_i) begin
        check("adc_sclk_periods", a_rises, 32'd16);
        check("adc_overlap", {31'd0, a_overlap}, 32'd0);
      end
      if (ufeed_en) begin
        if (exp_q.size() == 0) begin
          check("ufeed_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("adc_order", {31'd0, e.is_dac}, 32'd0);
          check("ufeed_value", {16'd0, ufeed}, {16'd0, e.val[15:0]});
        end
      end
      a_prev_cs   = adc_cs_n;
      a_prev_sclk = adc_sclk;
    end
  end

  task automatic do_write(input logic [15:0] d);
    wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (!busy) quiet++;
      else quiet = 0;
    end
    check("idle_timeout", {31'd0, quiet >= 4}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise, fall, csf, vld, rises;
    logic prev_s;
    rst_i = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_pins", {24'd0, ufeed_en, busy, dac_sclk, adc_sclk, dac_cs_n, adc_cs_n, dac_mosi, convst},
          32'b0000_1100);
    check("reset_ufeed", {16'd0, ufeed}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // DAC write of A55A: cs latency, frame content, gap and busy
    push_exp(1'b1, 24'h30A55A);
    do_write(16'hA55A);
    check("dac_cs_fall_latency", {31'd0, dac_cs_n}, 32'd0);
    check("dac_busy_start", {31'd0, busy}, 32'd1);
    repeat (199) @(negedge clk);
    check("dac_gap_cs_high", {31'd0, dac_cs_n}, 32'd1);
    check("dac_gap_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("dac_idle_busy", {31'd0, busy}, 32'd0);
    wait_idle();

    // ADC read of 1234 with convst/latency measurement
    push_sample(16'h1234);
    push_exp(1'b0, 24'h001234);
    do_read();
    rise = 0; fall = 0; csf = 0; vld = 0;
    for (int t = 1; t <= 1500; t++) begin
      if (convst && rise == 0) rise = t;
      if (!convst && rise != 0 && fall == 0) fall = t;
      if (!adc_cs_n && csf == 0) csf = t;
      if (ufeed_en && vld == 0) vld = t;
      if (vld != 0) break;
      @(negedge clk);
    end
    check("convst_rise_latency", rise, 32'd1);
    check("convst_high_cycles", fall - rise, 32'd4);
    check("convst_wait_cycles", csf - fall, 32'd100);
`ifndef MOTOR_ADC_AVG4_EN
    check("ufeed_latency", vld, 32'd233);
`endif
    repeat (5) @(negedge clk);
    check("ufeed_hold", {16'd0, ufeed}, 32'h1234);
    check("ufeed_single_pulse", {31'd0, ufeed_en}, 32'd0);
    wait_idle();

    // simultaneous write and read: read first, then DAC 300001
    push_sample(16'h0F0F);
    push_exp(1'b0, 24'h000F0F);
    push_exp(1'b1, 24'h300001);
    wr_data = 16'h0001; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    wait_idle();

    // three writes during an ADC frame collapse to the last one
    push_sample(16'hBEEF);
    push_exp(1'b0, 24'h00BEEF);
    push_exp(1'b1, 24'h300030);
    do_read();
    for (int i = 0; i < 400 && adc_cs_n; i++) @(negedge clk);
    check("adc_frame_started", {31'd0, adc_cs_n}, 32'd0);
    do_write(16'h0010);
    repeat (3) @(negedge clk);
    do_write(16'h0020);
    repeat (3) @(negedge clk);
    do_write(16'h0030);
    wait_idle();

    // reset in the middle of a DAC frame, then a clean FFFF frame
    do_write(16'h1357);
    rises = 0; prev_s = 1'b0;
    for (int i = 0; i < 400 && rises < 10; i++) begin
      @(negedge clk);
      if (dac_sclk && !prev_s) rises++;
      prev_s = dac_sclk;
    end
    abort_dac = 1'b1;
    rst_i = 1'b1;
    @(negedge clk);
    check("abort_cs_n", {31'd0, dac_cs_n}, 32'd1);
    check("abort_sclk", {31'd0, dac_sclk}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst_i = 1'b0;
    wait_idle();
    check("abort_no_frames_left", exp_q.size(), 32'd0);
    push_exp(1'b1, 24'h30FFFF);
    do_write(16'hFFFF);
    wait_idle();

`ifdef MOTOR_ADC_AVG4_EN
    // four samples averaged: (100+101+102+103)/4 = 101
    sample_q.push_back(16'd100);
    sample_q.push_back(16'd101);
    sample_q.push_back(16'd102);
    sample_q.push_back(16'd103);
    push_exp(1'b0, 24'd101);
    do_read();
    wait_idle();
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("samples_consumed", sample_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
